asconp_ctrl: RTL and testbench
==============================

ASCONP_CTRL -- requirements
Module: asconp_ctrl

Interface
REQ-001 Parameter UROL, default 1, rounds applied by the attached permutation datapath per clock; legal 1,2,3,4,6.
REQ-002 Parameter SBOX_WORDS, default 8, number of 21-bit configuration words forming one S-box LUT update.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 in_valid  in  1  permutation request valid.
REQ-006 in_ready  out  1  request accepted when in_valid && in_ready.
REQ-007 rounds_i  in  4  requested round count, sampled on request acceptance.
REQ-008 state_i  in  320  input state {x0,x1,x2,x3,x4}, x0 in [319:256].
REQ-009 out_valid  out  1  result valid.
REQ-010 out_ready  in  1  result consumed when out_valid && out_ready.
REQ-011 state_o  out  320  result state, same packing as state_i.
REQ-012 err_o  out  1  qualifies state_o: rounds_i was illegal, state returned unchanged.
REQ-013 cfg_valid  in  1  S-box configuration word valid.
REQ-014 cfg_data  in  21  S-box configuration word.
REQ-015 cfg_ready  out  1  word accepted when cfg_valid && cfg_ready.
REQ-016 upd_sbox  out  1  S-box LUT write strobe to datapath.
REQ-017 sbox_new_data_o  out  21  S-box LUT write data to datapath.
REQ-018 round_cnt  out  4  round counter to datapath.
REQ-019 perm_state_o  out  320  state driven into the datapath.
REQ-020 perm_state_i  in  320  datapath output, combinational function of perm_state_o and round_cnt.
REQ-021 busy  out  1  high whenever FSM is not IDLE.

Function
REQ-022 FSM states IDLE, CFG, RUN, DONE; internal 320-bit state register S drives perm_state_o and state_o.
REQ-023 IDLE: in_ready=1, cfg_ready=1; if cfg_valid and in_valid both high, configuration wins (in_ready forced 0 that cycle).
REQ-024 Config word accepted in IDLE: word count=1, go CFG (or stay IDLE if SBOX_WORDS==1).
REQ-025 CFG: cfg_ready=1, in_ready=0; each accepted word increments count; acceptance of word SBOX_WORDS returns to IDLE, count cleared.
REQ-026 Each accepted word produces upd_sbox=1 for exactly one cycle, the cycle after acceptance, with sbox_new_data_o = that word; otherwise upd_sbox=0, sbox_new_data_o holds last value.
REQ-027 Request accepted with legal rounds_i (1..12, multiple of UROL): S<=state_i, round_cnt<=rounds_i, go RUN.
REQ-028 Request accepted with illegal rounds_i (0, >12, not multiple of UROL): S<=state_i, err flag set, go DONE directly; datapath not advanced.
REQ-029 RUN: each cycle S<=perm_state_i, round_cnt<=round_cnt-UROL; when round_cnt==UROL go DONE; RUN lasts exactly rounds_i/UROL cycles.
REQ-030 round_cnt reads 0 outside RUN; first RUN cycle carries rounds_i so round constants start at 12-rounds_i (p12: 0xf0 first).
REQ-031 DONE: out_valid=1, state_o=S, err_o=err flag; hold stable until out_ready; on handshake go IDLE, clear err flag; out_valid deasserts next cycle.
REQ-032 Request accepted in IDLE yields out_valid at the earliest rounds_i/UROL+1 cycles after acceptance edge (1 cycle for illegal).
REQ-033 cfg_valid during RUN/DONE is stalled (cfg_ready=0), never dropped; in_valid during CFG/RUN/DONE stalled.
REQ-034 out_ready high before DONE has no effect; out_valid never asserted in IDLE, CFG, RUN.

Reset
REQ-035 rst asserted, at any time including mid-RUN or mid-CFG: FSM->IDLE, S=0, round_cnt=0, count=0, err flag=0, out_valid=0, upd_sbox=0, sbox_new_data_o=0, busy=0; in_ready and cfg_ready =1 from first cycle after rst deasserts.
REQ-036 A partially loaded S-box configuration aborted by reset is discarded; next accepted word counts as word 1.

Verification
REQ-037 UROL=1, rounds_i=12, state_i=0 -> busy 13 cycles, round_cnt sequence 12..1, state_o equals Ascon-p12(0) from golden model, err_o=0.
REQ-038 UROL=2, rounds_i=6 -> exactly 3 RUN cycles, round_cnt 6,4,2; state_o matches golden Ascon-p6.
REQ-039 rounds_i=0 and rounds_i=13 -> out_valid 1 cycle after acceptance, err_o=1, state_o==state_i.
REQ-040 cfg_valid and in_valid high together in IDLE, SBOX_WORDS=8 -> 8 upd_sbox pulses with matching data first, then request accepted.
REQ-041 out_ready held low 5 cycles in DONE -> state_o/out_valid stable, in_ready=0, new cfg stalled; released -> IDLE next cycle.
REQ-042 rst pulsed at RUN cycle 4 of p12 and after cfg word 3 -> all outputs reset values, next request runs full 12 rounds, next config needs 8 fresh words.

Source files
------------

// File: rtl/asconp_ctrl_if.sv
// ---------------------------------------------------------------------------
// asconp_ctrl_if
// Bundle of every handshake and data signal between the Ascon permutation
// controller and its surroundings:
//   request   : in_valid/in_ready, rounds_i, state_i
//   result    : out_valid/out_ready, state_o, err_o
//   config    : cfg_valid/cfg_ready, cfg_data
//   datapath  : upd_sbox, sbox_new_data_o, round_cnt, perm_state_o, perm_state_i
//   status    : busy
// modport slave  : the controller's view.
// modport master : the view of whoever drives requests/config and hosts the
//                  permutation datapath.
// ---------------------------------------------------------------------------
interface asconp_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   rounds_i;
    logic [319:0] state_i;
    logic         out_valid;
    logic         out_ready;
    logic [319:0] state_o;
    logic         err_o;
    logic         cfg_valid;
    logic [20:0]  cfg_data;
    logic         cfg_ready;
    logic         upd_sbox;
    logic [20:0]  sbox_new_data_o;
    logic [3:0]   round_cnt;
    logic [319:0] perm_state_o;
    logic [319:0] perm_state_i;
    logic         busy;

    modport slave (
        input  in_valid, rounds_i, state_i, out_ready, cfg_valid, cfg_data, perm_state_i,
        output in_ready, out_valid, state_o, err_o, cfg_ready, upd_sbox, sbox_new_data_o,
               round_cnt, perm_state_o, busy
    );

    modport master (
        output in_valid, rounds_i, state_i, out_ready, cfg_valid, cfg_data, perm_state_i,
        input  in_ready, out_valid, state_o, err_o, cfg_ready, upd_sbox, sbox_new_data_o,
               round_cnt, perm_state_o, busy
    );
endinterface

// File: rtl/asconp_ctrl.sv
// ---------------------------------------------------------------------------
// asconp_ctrl
// Control FSM for an external Ascon permutation datapath that applies UROL
// rounds per clock. Accepts a 320-bit state plus round count, iterates the
// datapath for rounds_i/UROL cycles and returns the result; illegal round
// counts are echoed back unchanged with err_o set. Between permutations it
// streams SBOX_WORDS 21-bit configuration words into the datapath S-box LUT.
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - asconp_ctrl_if.slave: request (in_*/rounds_i/state_i), result
//          (out_*/state_o/err_o), config (cfg_*), datapath (upd_sbox,
//          sbox_new_data_o, round_cnt, perm_state_o, perm_state_i), busy
// ---------------------------------------------------------------------------
module asconp_ctrl #(
    parameter int UROL       = 1,
    parameter int SBOX_WORDS = 8
) (
    input  logic         clk,
    input  logic         rst,
    asconp_ctrl_if.slave bus
);
    // Word counter only needs to hold 0..SBOX_WORDS-1: it clears on the last word.
    localparam int                 CNT_W     = (SBOX_WORDS > 1) ? $clog2(SBOX_WORDS) : 1;
    localparam logic [CNT_W-1:0]   LAST_WORD = CNT_W'(SBOX_WORDS - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]         STEP      = 4'(UROL);

    typedef enum logic [1:0] {IDLE, CFG, RUN, DONE} state_t;

    state_t             r_state;
    logic [319:0]       r_s;
    logic [3:0]         r_round_cnt;
    logic [CNT_W-1:0]   r_word_cnt;
    logic               r_err;
    logic               r_out_valid;
    logic               r_busy;
    logic               r_upd_sbox;
    logic [20:0]        r_sbox_data;

    logic               w_cfg_ready;
    logic               w_in_ready;
    logic               w_cfg_hs;
    logic               w_in_hs;
    logic               w_rounds_legal;

    // Configuration has priority over a simultaneous request in IDLE.
    assign w_cfg_ready    = (r_state == IDLE) || (r_state == CFG);
    assign w_in_ready     = (r_state == IDLE) && !bus.cfg_valid;
    assign w_cfg_hs       = bus.cfg_valid && w_cfg_ready;
    assign w_in_hs        = bus.in_valid && w_in_ready;
    assign w_rounds_legal = (bus.rounds_i != 4'd0) && (bus.rounds_i <= 4'd12) &&
                            ((bus.rounds_i % STEP) == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_s         <= '0;
            r_round_cnt <= '0;
            r_word_cnt  <= '0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_upd_sbox  <= 1'b0;
            r_sbox_data <= '0;
        end else begin
            // LUT write strobe trails word acceptance by one cycle.
            r_upd_sbox <= w_cfg_hs;
            if (w_cfg_hs) begin
                r_sbox_data <= bus.cfg_data;
            end

            case (r_state)
                IDLE: begin
                    if (w_cfg_hs) begin
                        if (SBOX_WORDS > 1) begin
                            r_word_cnt <= CNT_ONE;
                            r_state    <= CFG;
                            r_busy     <= 1'b1;
                        end
                    end else if (w_in_hs) begin
                        r_s    <= bus.state_i;
                        r_busy <= 1'b1;
                        if (w_rounds_legal) begin
                            r_round_cnt <= bus.rounds_i;
                            r_state     <= RUN;
                        end else begin
                            // Illegal count: skip the datapath, echo the input.
                            r_err       <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end
                    end
                end
                CFG: begin
                    if (w_cfg_hs) begin
                        if (r_word_cnt == LAST_WORD) begin
                            r_word_cnt <= '0;
                            r_state    <= IDLE;
                            r_busy     <= 1'b0;
                        end else begin
                            r_word_cnt <= r_word_cnt + CNT_ONE;
                        end
                    end
                end
                RUN: begin
                    r_s <= bus.perm_state_i;
                    // round_cnt falls to 0 on the last step so it reads 0 outside RUN.
                    if (r_round_cnt == STEP) begin
                        r_round_cnt <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_round_cnt <= r_round_cnt - STEP;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_err       <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready        = w_in_ready;
    assign bus.cfg_ready       = w_cfg_ready;
    assign bus.out_valid       = r_out_valid;
    assign bus.state_o         = r_s;
    assign bus.err_o           = r_err;
    assign bus.perm_state_o    = r_s;
    assign bus.round_cnt       = r_round_cnt;
    assign bus.upd_sbox        = r_upd_sbox;
    assign bus.sbox_new_data_o = r_sbox_data;
    assign bus.busy            = r_busy;

endmodule

// File: tb/tb_asconp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_asconp_ctrl
// Two controllers: dut_a (UROL=1) and dut_b (UROL=2), each with an Ascon
// round datapath modelled in the bench. dut_a is tracked every cycle by a
// transaction-level model; both get directed checks with literal values.
// ---------------------------------------------------------------------------
module tb_asconp_ctrl;
    localparam int UA = 1;
    localparam int UB = 2;
    localparam int SW = 8;

    localparam logic [319:0] S1 = {64'h0123456789abcdef, 64'hfedcba9876543210,
                                   64'h0f0f0f0f0f0f0f0f, 64'h8000000000000001, 64'hdeadbeefcafebabe};
    localparam logic [319:0] S2 = {64'h80400c0600000000, 64'h0001020304050607,
                                   64'h08090a0b0c0d0e0f, 64'h0011223344556677, 64'h8899aabbccddeeff};
    localparam logic [319:0] S3 = {64'hffffffffffffffff, 64'h0000000000000000,
                                   64'haaaaaaaaaaaaaaaa, 64'h5555555555555555, 64'h1234567812345678};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    asconp_ctrl_if ifa();
    asconp_ctrl_if ifb();

    asconp_ctrl #(.UROL(UA), .SBOX_WORDS(SW)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    asconp_ctrl #(.UROL(UB), .SBOX_WORDS(SW)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    // ---------------- Ascon reference ----------------
    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] ascon_round(input logic [319:0] s, input int i);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        x2 = x2 ^ 64'(((15 - i) << 4) | i);
        x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
        x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    // Ascon-pR on a whole state: rounds 12-R .. 11.
    function automatic logic [319:0] perm(input logic [319:0] s, input int r);
        logic [319:0] t;
        t = s;
        for (int i = 12 - r; i < 12; i++) t = ascon_round(t, i);
        return t;
    endfunction

    // Datapath: u rounds per clock starting at round index 12-rc.
    function automatic logic [319:0] dp(input logic [319:0] s, input logic [3:0] rc, input int u);
        logic [319:0] t;
        t = s;
        if (rc != 4'd0)
            for (int k = 0; k < u; k++) t = ascon_round(t, 12 - int'(rc) + k);
        return t;
    endfunction

    assign ifa.perm_state_i = dp(ifa.perm_state_o, ifa.round_cnt, UA);
    assign ifb.perm_state_i = dp(ifb.perm_state_o, ifb.round_cnt, UB);

    task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- transaction model of dut_a ----------------
    typedef struct {
        logic [319:0] st;
        logic         err;
        int           r;
        int           lat;
        int           acc;
    } exp_t;

    exp_t        q[$];
    int          cfg_cnt  = 0;
    logic [20:0] last_w   = '0;
    logic        upd_e    = 1'b0;
    int          pulses_a = 0;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_out_valid", 320'(ifa.out_valid), 320'(0));
            chk("rst_busy",      320'(ifa.busy), 320'(0));
            chk("rst_upd_sbox",  320'(ifa.upd_sbox), 320'(0));
            chk("rst_sbox_data", 320'(ifa.sbox_new_data_o), 320'(0));
            chk("rst_round_cnt", 320'(ifa.round_cnt), 320'(0));
            chk("rst_state_o",   ifa.state_o, 320'(0));
            chk("rst_err_o",     320'(ifa.err_o), 320'(0));
            q.delete();
            cfg_cnt = 0;
            last_w  = '0;
            upd_e   = 1'b0;
        end else begin
            bit   idle, cfg_rdy, in_rdy, cfg_hs, in_hs, ov, legal;
            int   el, rc, r;
            exp_t e;
            idle    = (q.size() == 0) && (cfg_cnt == 0);
            cfg_rdy = (q.size() == 0);
            in_rdy  = idle && !ifa.cfg_valid;
            ov = 1'b0;
            rc = 0;
            if (q.size() > 0) begin
                el = cyc - q[0].acc;
                ov = (el >= q[0].lat);
                if (!q[0].err && el >= 1 && el * UA <= q[0].r) rc = q[0].r - (el - 1) * UA;
            end
            chk("a_busy",      320'(ifa.busy), 320'(!idle));
            chk("a_in_ready",  320'(ifa.in_ready), 320'(in_rdy));
            chk("a_cfg_ready", 320'(ifa.cfg_ready), 320'(cfg_rdy));
            chk("a_upd_sbox",  320'(ifa.upd_sbox), 320'(upd_e));
            chk("a_sbox_data", 320'(ifa.sbox_new_data_o), 320'(last_w));
            chk("a_out_valid", 320'(ifa.out_valid), 320'(ov));
            chk("a_round_cnt", 320'(ifa.round_cnt), 320'(rc));
            if (ifa.upd_sbox) pulses_a++;
            if (ov) begin
                chk("a_state_o", ifa.state_o, q[0].st);
                chk("a_err_o",   320'(ifa.err_o), 320'(q[0].err));
                if (ifa.out_ready) q.delete(0);
            end
            cfg_hs = ifa.cfg_valid && cfg_rdy;
            in_hs  = ifa.in_valid && in_rdy;
            upd_e  = cfg_hs;
            if (cfg_hs) begin
                last_w  = ifa.cfg_data;
                cfg_cnt = (cfg_cnt + 1) % SW;
            end
            if (in_hs) begin
                r      = int'(ifa.rounds_i);
                legal  = (r >= 1) && (r <= 12) && (r % UA == 0);
                e.st   = legal ? perm(ifa.state_i, r) : ifa.state_i;
                e.err  = !legal;
                e.r    = r;
                e.lat  = legal ? r / UA + 1 : 1;
                e.acc  = cyc;
                q.push_back(e);
            end
        end
    end

    // ---------------- dut_a stimulus helpers ----------------
    task automatic a_req(input logic [3:0] r, input logic [319:0] st);
        bit ok;
        int t;
        ifa.in_valid = 1'b1; ifa.rounds_i = r; ifa.state_i = st;
        ok = 1'b0; t = 0;
        do begin
            @(negedge clk); ok = ifa.in_ready;
            @(posedge clk); #1; t++;
        end while (!ok && t < 200);
        ifa.in_valid = 1'b0;
        chk("a_req_accept", 320'(ok), 320'(1));
    endtask

    task automatic a_cfg(input logic [20:0] w);
        bit ok;
        int t;
        ifa.cfg_valid = 1'b1; ifa.cfg_data = w;
        ok = 1'b0; t = 0;
        do begin
            @(negedge clk); ok = ifa.cfg_ready;
            @(posedge clk); #1; t++;
        end while (!ok && t < 200);
        ifa.cfg_valid = 1'b0;
        chk("a_cfg_accept", 320'(ok), 320'(1));
    endtask

    task automatic a_drain();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!ifa.busy) break;
        end
        chk("a_drain_idle", 320'(ifa.busy), 320'(0));
        @(posedge clk); #1;
    endtask

    task automatic a_p12(input logic [319:0] st);
        int         n;
        logic [3:0] seq [0:15];
        for (int k = 0; k < 16; k++) seq[k] = '0;
        a_req(4'd12, st);
        n = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!ifa.busy) break;
            if (n < 16) seq[n] = ifa.round_cnt;
            if (ifa.out_valid) begin
                chk("p12_state", ifa.state_o, perm(st, 12));
                chk("p12_err", 320'(ifa.err_o), 320'(0));
            end
            n++;
        end
        chk("p12_busy_cycles", 320'(n), 320'(13));
        chk("p12_rc_first", 320'(seq[0]), 320'(12));
        chk("p12_rc_5th", 320'(seq[4]), 320'(8));
        chk("p12_rc_last", 320'(seq[11]), 320'(1));
        chk("p12_rc_in_done", 320'(seq[12]), 320'(0));
        @(posedge clk); #1;
    endtask

    task automatic a_bad(input logic [3:0] r, input logic [319:0] st);
        a_req(r, st);
        @(negedge clk);
        chk("bad_a_out_valid", 320'(ifa.out_valid), 320'(1));
        chk("bad_a_err", 320'(ifa.err_o), 320'(1));
        chk("bad_a_state", ifa.state_o, st);
        @(posedge clk); #1;
        a_drain();
    endtask

    // ---------------- dut_b stimulus helpers ----------------
    task automatic b_req(input logic [3:0] r, input logic [319:0] st);
        bit ok;
        int t;
        ifb.in_valid = 1'b1; ifb.rounds_i = r; ifb.state_i = st;
        ok = 1'b0; t = 0;
        do begin
            @(negedge clk); ok = ifb.in_ready;
            @(posedge clk); #1; t++;
        end while (!ok && t < 200);
        ifb.in_valid = 1'b0;
        chk("b_req_accept", 320'(ok), 320'(1));
    endtask

    task automatic b_legal(input logic [3:0] r, input logic [319:0] st, input int exp_n,
                           input logic [3:0] exp_first, input logic [3:0] exp_last);
        int         n;
        logic [3:0] seq [0:15];
        for (int k = 0; k < 16; k++) seq[k] = '0;
        b_req(r, st);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ifb.out_valid) break;
            if (n < 16) seq[n] = ifb.round_cnt;
            n++;
        end
        chk("b_run_cycles", 320'(n), 320'(exp_n));
        chk("b_rc_first", 320'(seq[0]), 320'(exp_first));
        chk("b_rc_last", 320'(seq[exp_n - 1]), 320'(exp_last));
        chk("b_out_valid", 320'(ifb.out_valid), 320'(1));
        chk("b_state", ifb.state_o, perm(st, int'(r)));
        chk("b_err", 320'(ifb.err_o), 320'(0));
        if (r == 4'd6) chk("b_p6_rc_mid", 320'(seq[1]), 320'(4));
        @(posedge clk); #1;
        @(negedge clk);
        chk("b_idle_after", 320'(ifb.out_valid), 320'(0));
        @(posedge clk); #1;
    endtask

    task automatic b_bad(input logic [3:0] r, input logic [319:0] st);
        b_req(r, st);
        @(negedge clk);
        chk("bad_b_out_valid", 320'(ifb.out_valid), 320'(1));
        chk("bad_b_err", 320'(ifb.err_o), 320'(1));
        chk("bad_b_state", ifb.state_o, st);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bad_b_released", 320'(ifb.busy), 320'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    logic [20:0] W [0:10];

    initial begin
        int pb;
        bit ok;
        W[0] = 21'h1abcde; W[1] = 21'h000001; W[2] = 21'h100000; W[3] = 21'h0f0f0f;
        W[4] = 21'h1fffff; W[5] = 21'h0a5a5a; W[6] = 21'h123456; W[7] = 21'h054321;
        W[8] = 21'h155555; W[9] = 21'h0aaaaa; W[10] = 21'h013579;

        ifa.in_valid = 0; ifa.rounds_i = '0; ifa.state_i = '0; ifa.out_ready = 1;
        ifa.cfg_valid = 0; ifa.cfg_data = '0;
        ifb.in_valid = 0; ifb.rounds_i = '0; ifb.state_i = '0; ifb.out_ready = 1;
        ifb.cfg_valid = 0; ifb.cfg_data = '0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("init_in_ready", 320'(ifa.in_ready), 320'(1));
        chk("init_cfg_ready", 320'(ifa.cfg_ready), 320'(1));
        chk("init_b_in_ready", 320'(ifb.in_ready), 320'(1));
        @(posedge clk); #1;

        // UROL=2
        b_legal(4'd6, S1, 3, 4'd6, 4'd2);
        b_legal(4'd12, S2, 6, 4'd12, 4'd2);
        b_bad(4'd5, S3);
        b_bad(4'd14, S1);

        // UROL=1: p12 of zero state and other round counts
        a_p12('0);
        a_p12(S1);
        a_req(4'd1, S2);  a_drain();
        a_req(4'd5, S3);  a_drain();
        a_bad(4'd0, S1);
        a_bad(4'd13, S2);
        a_bad(4'd15, S3);

        // simultaneous config and request: config first
        pb = pulses_a;
        ifa.in_valid = 1'b1; ifa.rounds_i = 4'd4; ifa.state_i = S2;
        ifa.cfg_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ifa.cfg_data = W[i];
            @(negedge clk);
            chk("both_in_ready_low", 320'(ifa.in_ready), 320'(0));
            chk("both_cfg_ready", 320'(ifa.cfg_ready), 320'(1));
            @(posedge clk); #1;
        end
        ifa.cfg_valid = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk); ok = ifa.in_ready;
            @(posedge clk); #1;
        end
        ifa.in_valid = 1'b0;
        chk("both_req_accept", 320'(ok), 320'(1));
        a_drain();
        chk("both_pulse_count", 320'(pulses_a - pb), 320'(8));
        chk("both_last_data", 320'(ifa.sbox_new_data_o), 320'(W[7]));

        // result held while out_ready low
        ifa.out_ready = 1'b0;
        a_req(4'd2, S1);
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk); ok = ifa.out_valid;
        end
        chk("hold_seen_valid", 320'(ok), 320'(1));
        @(posedge clk); #1;
        ifa.cfg_valid = 1'b1; ifa.cfg_data = W[8];
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_out_valid", 320'(ifa.out_valid), 320'(1));
            chk("hold_state", ifa.state_o, perm(S1, 2));
            chk("hold_in_ready", 320'(ifa.in_ready), 320'(0));
            chk("hold_cfg_ready", 320'(ifa.cfg_ready), 320'(0));
            @(posedge clk); #1;
        end
        ifa.out_ready = 1'b1;
        a_cfg(W[8]);
        a_cfg(W[9]);
        a_cfg(W[10]);

        // reset after three config words
        @(negedge clk);
        chk("cfg3_busy", 320'(ifa.busy), 320'(1));
        #2 rst = 1'b1;
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 320'(ifa.in_ready), 320'(1));
        chk("post_rst_cfg_ready", 320'(ifa.cfg_ready), 320'(1));
        chk("post_rst_busy", 320'(ifa.busy), 320'(0));
        @(posedge clk); #1;
        for (int i = 0; i < 7; i++) a_cfg(W[i]);
        @(negedge clk);
        chk("fresh7_busy", 320'(ifa.busy), 320'(1));
        @(posedge clk); #1;
        a_cfg(W[7]);
        @(negedge clk);
        chk("fresh8_busy", 320'(ifa.busy), 320'(0));
        @(posedge clk); #1;

        // reset during RUN cycle 4 of p12
        a_req(4'd12, S3);
        repeat (4) @(negedge clk);
        chk("run4_round_cnt", 320'(ifa.round_cnt), 320'(9));
        #2 rst = 1'b1;
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrun_rst_state", ifa.state_o, 320'(0));
        chk("midrun_rst_in_ready", 320'(ifa.in_ready), 320'(1));
        @(posedge clk); #1;
        a_p12(S3);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
